// File: rtl/wbu_pkg.sv
// Shared types and constants for the writeback/commit stage: CSR map, op codes, FSM states.
package wbu_pkg;

    typedef enum logic [1:0] {
        CSR_NONE = 2'd0,
        CSR_RW   = 2'd1,
        CSR_RS   = 2'd2,
        CSR_RC   = 2'd3
    } csr_op_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COMMIT   = 2'd1,
        ST_REDIRECT = 2'd2
    } wbu_state_e;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;

    localparam logic [31:0] MSTATUS_RST    = 32'h0000_1800;
    localparam logic [31:0] MVENDORID_VAL  = 32'h7973_7978;
    localparam logic [31:0] MARCHID_VAL    = 32'd25030093;
    localparam logic [31:0] MCAUSE_ECALL_M = 32'd11;

endpackage

// File: rtl/wbu_gpr_file.sv
// GPR array with one write port and combinational read ports; reads bypass the write landing this cycle.
// x0 and addresses beyond NR_REGS read zero and are never written.
module wbu_gpr_file #(
    parameter int DATA_WIDTH  = 32,
    parameter int NR_REGS     = 32,
    parameter int NR_RD_PORTS = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              wen,
    input  logic [4:0]                        waddr,
    input  logic [DATA_WIDTH-1:0]             wdata,
    input  logic [NR_RD_PORTS*5-1:0]          raddr,
    output logic [NR_RD_PORTS*DATA_WIDTH-1:0] rdata
);

    localparam int          IDX_W  = $clog2(NR_REGS);
    localparam logic [5:0]  NR_LIM = 6'(NR_REGS);

    logic [DATA_WIDTH-1:0] regs_q [NR_REGS];
    logic                  wr_ok;

    function automatic logic addr_ok(input logic [4:0] a);
        return (a != 5'd0) && ({1'b0, a} < NR_LIM);
    endfunction

    assign wr_ok = wen && addr_ok(waddr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NR_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_ok) begin
            regs_q[waddr[IDX_W-1:0]] <= wdata;
        end
    end

    always_comb begin
        rdata = '0;
        for (int p = 0; p < NR_RD_PORTS; p++) begin
            if (addr_ok(raddr[5*p +: 5])) begin
                if (wr_ok && (waddr == raddr[5*p +: 5])) begin
                    rdata[p*DATA_WIDTH +: DATA_WIDTH] = wdata;
                end else begin
                    rdata[p*DATA_WIDTH +: DATA_WIDTH] = regs_q[raddr[5*p +: IDX_W]];
                end
            end
        end
    end

endmodule

// File: rtl/wbu_commit_stage.sv
// Writeback/commit stage: holds one retiring instruction, commits GPR/CSR writes one edge after accept,
// and stalls upstream (in_ready low) while an ecall/mret redirect waits for the IFU handshake.
module wbu_commit_stage
    import wbu_pkg::*;
#(
    parameter int          DATA_WIDTH  = 32,
    parameter int          NR_REGS     = 32,
    parameter int          NR_RD_PORTS = 2,
    parameter logic [31:0] MTVEC_RST   = 32'h0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [31:0]                       in_pc,
    input  logic [4:0]                        in_rd,
    input  logic                              in_rd_wen,
    input  logic [DATA_WIDTH-1:0]             in_rd_data,
    input  logic [1:0]                        in_csr_op,
    input  logic [11:0]                       in_csr_addr,
    input  logic [DATA_WIDTH-1:0]             in_csr_src,
    input  logic                              in_ecall,
    input  logic                              in_mret,
    input  logic [NR_RD_PORTS*5-1:0]          rs_addr,
    output logic [NR_RD_PORTS*DATA_WIDTH-1:0] rs_data,
    output logic                              redirect_valid,
    input  logic                              redirect_ready,
    output logic [31:0]                       redirect_pc,
    output logic                              commit_valid,
    output logic [31:0]                       commit_pc
);

    wbu_state_e            state_q, state_d;
    logic                  accept, trap_take;

    logic [31:0]           pc_q;
    logic [4:0]            rd_q;
    logic                  rd_wen_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    csr_op_e               csr_op_q;
    logic [11:0]           csr_addr_q;
    logic [DATA_WIDTH-1:0] csr_src_q;
    logic                  ecall_q;

    logic [DATA_WIDTH-1:0] mstatus_q, mtvec_q, mepc_q, mcause_q;
    logic [DATA_WIDTH-1:0] csr_old, csr_new, gpr_wdata;
    logic                  csr_wen, gpr_wen;

    assign accept    = in_valid && in_ready;
    assign trap_take = (state_q == ST_REDIRECT) && redirect_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_COMMIT: begin
                if (in_valid) begin
                    state_d = (in_ecall || in_mret) ? ST_REDIRECT : ST_COMMIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REDIRECT: begin
                if (redirect_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        commit_valid   = 1'b0;
        commit_pc      = 32'h0;
        case (state_q)
            ST_COMMIT: begin
                commit_valid = 1'b1;
                commit_pc    = pc_q;
            end
            ST_REDIRECT: begin
                in_ready       = 1'b0;
                redirect_valid = 1'b1;
                redirect_pc    = ecall_q ? mtvec_q[31:0] : mepc_q[31:0];
                if (redirect_ready) begin
                    commit_valid = 1'b1;
                    commit_pc    = pc_q;
                end
            end
            default: ;
        endcase
    end

    // Held fields only change on accept so redirect_pc and commit_pc stay stable while stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q       <= '0;
            rd_q       <= '0;
            rd_wen_q   <= 1'b0;
            rd_data_q  <= '0;
            csr_op_q   <= CSR_NONE;
            csr_addr_q <= '0;
            csr_src_q  <= '0;
            ecall_q    <= 1'b0;
        end else if (accept) begin
            pc_q       <= in_pc;
            rd_q       <= in_rd;
            rd_wen_q   <= in_rd_wen;
            rd_data_q  <= in_rd_data;
            csr_op_q   <= csr_op_e'(in_csr_op);
            csr_addr_q <= in_csr_addr;
            csr_src_q  <= in_csr_src;
            ecall_q    <= in_ecall;
        end
    end

    always_comb begin
        csr_old = '0;
        case (csr_addr_q)
            CSR_MSTATUS:   csr_old = mstatus_q;
            CSR_MTVEC:     csr_old = mtvec_q;
            CSR_MEPC:      csr_old = mepc_q;
            CSR_MCAUSE:    csr_old = mcause_q;
            CSR_MVENDORID: csr_old = DATA_WIDTH'(MVENDORID_VAL);
            CSR_MARCHID:   csr_old = DATA_WIDTH'(MARCHID_VAL);
            default:       csr_old = '0;
        endcase
    end

    always_comb begin
        csr_new = csr_old;
        case (csr_op_q)
            CSR_RW:  csr_new = csr_src_q;
            CSR_RS:  csr_new = csr_old | csr_src_q;
            CSR_RC:  csr_new = csr_old & ~csr_src_q;
            default: csr_new = csr_old;
        endcase
    end

    // Traps never sit in COMMIT, so ecall/mret can never trigger these write enables.
    assign csr_wen   = (state_q == ST_COMMIT) && (csr_op_q != CSR_NONE);
    assign gpr_wen   = (state_q == ST_COMMIT) && rd_wen_q;
    assign gpr_wdata = (csr_op_q != CSR_NONE) ? csr_old : rd_data_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mstatus_q <= DATA_WIDTH'(MSTATUS_RST);
            mtvec_q   <= DATA_WIDTH'(MTVEC_RST);
            mepc_q    <= '0;
            mcause_q  <= '0;
        end else begin
            if (csr_wen) begin
                case (csr_addr_q)
                    CSR_MSTATUS: mstatus_q <= csr_new;
                    CSR_MTVEC:   mtvec_q   <= csr_new;
                    CSR_MEPC:    mepc_q    <= csr_new;
                    CSR_MCAUSE:  mcause_q  <= csr_new;
                    default: ;
                endcase
            end
            if (trap_take && ecall_q) begin
                mepc_q   <= DATA_WIDTH'(pc_q);
                mcause_q <= DATA_WIDTH'(MCAUSE_ECALL_M);
            end
        end
    end

    wbu_gpr_file #(
        .DATA_WIDTH  (DATA_WIDTH),
        .NR_REGS     (NR_REGS),
        .NR_RD_PORTS (NR_RD_PORTS)
    ) u_gpr (
        .clk   (clk),
        .rst   (rst),
        .wen   (gpr_wen),
        .waddr (rd_q),
        .wdata (gpr_wdata),
        .raddr (rs_addr),
        .rdata (rs_data)
    );

endmodule

// File: tb/tb_wbu_commit_stage.sv
// Bench for wbu_commit_stage: directed vector table, hand sequences for bypass/trap/reset corners,
// and randomized instruction streams checked against an instruction-level model.
module tb_wbu_commit_stage;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        wen;
        logic [31:0] data;
        logic [1:0]  op;
        logic [11:0] addr;
        logic [31:0] src;
        logic        ecall;
        logic        mret;
    } instr_t;

    typedef struct {
        instr_t      i;
        int          chk_reg;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, in_rd_wen, in_ecall, in_mret;
    logic [31:0] in_pc, in_rd_data, in_csr_src;
    logic [4:0]  in_rd;
    logic [1:0]  in_csr_op;
    logic [11:0] in_csr_addr;
    logic [9:0]  rs_addr;
    logic [63:0] rs_data;
    logic        redirect_valid, redirect_ready, commit_valid;
    logic [31:0] redirect_pc, commit_pc;

    logic        s_in_valid, s_in_ready, s_in_rd_wen, s_redirect_valid, s_commit_valid;
    logic [31:0] s_in_rd_data, s_redirect_pc, s_commit_pc;
    logic [4:0]  s_in_rd;
    logic [9:0]  s_rs_addr;
    logic [63:0] s_rs_data;

    wbu_commit_stage #(.DATA_WIDTH(32), .NR_REGS(32), .NR_RD_PORTS(2), .MTVEC_RST(32'h0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_rd(in_rd), .in_rd_wen(in_rd_wen), .in_rd_data(in_rd_data), .in_csr_op(in_csr_op),
        .in_csr_addr(in_csr_addr), .in_csr_src(in_csr_src), .in_ecall(in_ecall), .in_mret(in_mret),
        .rs_addr(rs_addr), .rs_data(rs_data), .redirect_valid(redirect_valid),
        .redirect_ready(redirect_ready), .redirect_pc(redirect_pc), .commit_valid(commit_valid),
        .commit_pc(commit_pc)
    );

    wbu_commit_stage #(.DATA_WIDTH(32), .NR_REGS(16), .NR_RD_PORTS(2), .MTVEC_RST(32'h0)) dut16 (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_pc(32'h0),
        .in_rd(s_in_rd), .in_rd_wen(s_in_rd_wen), .in_rd_data(s_in_rd_data), .in_csr_op(2'd0),
        .in_csr_addr(12'h0), .in_csr_src(32'h0), .in_ecall(1'b0), .in_mret(1'b0),
        .rs_addr(s_rs_addr), .rs_data(s_rs_data), .redirect_valid(s_redirect_valid),
        .redirect_ready(1'b0), .redirect_pc(s_redirect_pc), .commit_valid(s_commit_valid),
        .commit_pc(s_commit_pc)
    );

    int n_checks = 0;
    int n_fail = 0;
    int commit_cnt = 0;
    int exp_commits = 0;

    logic [31:0] m_gpr [32];
    logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause;

    always @(negedge clk) begin
        #2;
        if (commit_valid === 1'b1) commit_cnt++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) m_gpr[r] = 32'h0;
        m_mstatus = 32'h1800;
        m_mtvec   = 32'h0;
        m_mepc    = 32'h0;
        m_mcause  = 32'h0;
    endtask

    function automatic logic [31:0] m_csr_rd(input logic [11:0] a);
        case (a)
            12'h300: return m_mstatus;
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'hF11: return 32'h7973_7978;
            12'hF12: return 32'd25030093;
            default: return 32'h0;
        endcase
    endfunction

    // Architectural effect of one instruction, applied when it is issued.
    task automatic model_exec(input instr_t i, output logic trap, output logic [31:0] tgt);
        logic [31:0] old, nv;
        trap = 1'b0;
        tgt  = 32'h0;
        if (i.ecall) begin
            trap = 1'b1;
            tgt  = m_mtvec;
            m_mepc   = i.pc;
            m_mcause = 32'd11;
        end else if (i.mret) begin
            trap = 1'b1;
            tgt  = m_mepc;
        end else begin
            old = m_csr_rd(i.addr);
            if (i.op != 2'd0) begin
                nv = (i.op == 2'd1) ? i.src : (i.op == 2'd2) ? (old | i.src) : (old & ~i.src);
                case (i.addr)
                    12'h300: m_mstatus = nv;
                    12'h305: m_mtvec   = nv;
                    12'h341: m_mepc    = nv;
                    12'h342: m_mcause  = nv;
                    default: ;
                endcase
            end
            if (i.wen && i.rd != 5'd0) m_gpr[i.rd] = (i.op != 2'd0) ? old : i.data;
        end
    endtask

    function automatic instr_t mk(input logic [31:0] pc, input int rd, input logic wen,
                                  input logic [31:0] data, input int op, input logic [11:0] addr,
                                  input logic [31:0] src, input logic ec, input logic mr);
        instr_t t;
        t.pc = pc; t.rd = 5'(rd); t.wen = wen; t.data = data; t.op = 2'(op);
        t.addr = addr; t.src = src; t.ecall = ec; t.mret = mr;
        return t;
    endfunction

    task automatic drive(input instr_t i);
        in_valid = 1'b1; in_pc = i.pc; in_rd = i.rd; in_rd_wen = i.wen; in_rd_data = i.data;
        in_csr_op = i.op; in_csr_addr = i.addr; in_csr_src = i.src; in_ecall = i.ecall; in_mret = i.mret;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0; in_ecall = 1'b0; in_mret = 1'b0;
    endtask

    task automatic run_instr(input instr_t i, input int dly);
        logic trap;
        logic [31:0] tgt;
        @(negedge clk);
        drive(i);
        model_exec(i, trap, tgt);
        exp_commits++;
        if (trap) begin
            for (int k = 0; k <= dly; k++) begin
                @(negedge clk);
                if (k == 0) begin
                    in_valid = 1'b0; in_ecall = 1'b0; in_mret = 1'b0;
                end
                redirect_ready = (k == dly);
                #1;
                chk1("redirect_valid_held", redirect_valid, 1'b1);
                chk("redirect_pc", redirect_pc, tgt);
                chk1("in_ready_during_redirect", in_ready, 1'b0);
                chk1("commit_on_handshake_only", commit_valid, k == dly);
                if (k == dly) chk("trap_commit_pc", commit_pc, i.pc);
            end
            @(negedge clk);
            redirect_ready = 1'b0;
            #1;
            chk1("redirect_released", redirect_valid, 1'b0);
        end
    endtask

    task automatic rd_gpr(input int r, output logic [31:0] v);
        @(negedge clk);
        in_valid = 1'b0; in_ecall = 1'b0; in_mret = 1'b0;
        rs_addr = {5'(r), 5'(r)};
        #1;
        v = rs_data[31:0];
    endtask

    task automatic rd_csr(input logic [11:0] a, output logic [31:0] v);
        run_instr(mk(32'h0000_0100, 31, 1'b1, 32'h0, 2, a, 32'h0, 1'b0, 1'b0), 0);
        rd_gpr(31, v);
    endtask

    function automatic logic [11:0] rand_addr();
        case ($urandom_range(0, 6))
            0: return 12'h300;
            1: return 12'h305;
            2: return 12'h341;
            3: return 12'h342;
            4: return 12'hF11;
            5: return 12'hF12;
            default: return 12'h7C0;
        endcase
    endfunction

    vec_t tbl [14];

    initial begin
        logic [31:0] v;
        int c0;
        instr_t ri;

        tbl[0]  = '{mk(32'h8000_0000, 6, 1'b1, 32'h0, 1, 12'h305, 32'h8000_0100, 1'b0, 1'b0), 6, 32'h0};
        tbl[1]  = '{mk(32'h8000_0004, 7, 1'b1, 32'h0, 2, 12'h305, 32'h0000_000F, 1'b0, 1'b0), 7, 32'h8000_0100};
        tbl[2]  = '{mk(32'h8000_0008, 8, 1'b1, 32'h0, 3, 12'h305, 32'h0000_000F, 1'b0, 1'b0), 8, 32'h8000_010F};
        tbl[3]  = '{mk(32'h8000_000C, 9, 1'b1, 32'h0, 2, 12'h305, 32'h0, 1'b0, 1'b0), 9, 32'h8000_0100};
        tbl[4]  = '{mk(32'h8000_0010, 10, 1'b1, 32'h0, 2, 12'hF11, 32'h0, 1'b0, 1'b0), 10, 32'h7973_7978};
        tbl[5]  = '{mk(32'h8000_0014, 11, 1'b1, 32'h0, 1, 12'hF12, 32'h5, 1'b0, 1'b0), 11, 32'd25030093};
        tbl[6]  = '{mk(32'h8000_0018, 12, 1'b1, 32'h0, 2, 12'hF12, 32'h0, 1'b0, 1'b0), 12, 32'd25030093};
        tbl[7]  = '{mk(32'h8000_001C, 13, 1'b1, 32'h0, 1, 12'h7C0, 32'hABCD, 1'b0, 1'b0), 13, 32'h0};
        tbl[8]  = '{mk(32'h8000_0020, 14, 1'b1, 32'h0, 2, 12'h7C0, 32'h0, 1'b0, 1'b0), 14, 32'h0};
        tbl[9]  = '{mk(32'h8000_0024, 15, 1'b1, 32'h0000_A5A5, 0, 12'h305, 32'hFFFF, 1'b0, 1'b0), 15, 32'h0000_A5A5};
        tbl[10] = '{mk(32'h8000_0028, 16, 1'b1, 32'hFFFF, 2, 12'h342, 32'h0, 1'b0, 1'b0), 16, 32'h0};
        tbl[11] = '{mk(32'h8000_002C, 17, 1'b0, 32'h0, 1, 12'h341, 32'h1234, 1'b0, 1'b0), 17, 32'h0};
        tbl[12] = '{mk(32'h8000_0030, 18, 1'b1, 32'h0, 2, 12'h341, 32'h0, 1'b0, 1'b0), 18, 32'h1234};
        tbl[13] = '{mk(32'h8000_0034, 19, 1'b1, 32'h0, 1, 12'h300, 32'h1800, 1'b0, 1'b0), 19, 32'h1800};

        in_valid = 0; in_pc = 0; in_rd = 0; in_rd_wen = 0; in_rd_data = 0; in_csr_op = 0;
        in_csr_addr = 0; in_csr_src = 0; in_ecall = 0; in_mret = 0; rs_addr = 0; redirect_ready = 0;
        s_in_valid = 0; s_in_rd = 0; s_in_rd_wen = 0; s_in_rd_data = 0; s_rs_addr = 0;
        model_reset();

        #12 rst = 1'b1;
        @(negedge clk);
        rs_addr = {5'd3, 5'd1};
        #1;
        chk1("rst_in_ready", in_ready, 1'b1);
        chk1("rst_commit_valid", commit_valid, 1'b0);
        chk1("rst_redirect_valid", redirect_valid, 1'b0);
        chk("rst_redirect_pc", redirect_pc, 32'h0);
        chk("rst_commit_pc", commit_pc, 32'h0);
        chk("rst_rs_data", rs_data[31:0] | rs_data[63:32], 32'h0);

        // csrrs x5, mstatus, x0 with junk rd_data that must be ignored
        c0 = commit_cnt;
        run_instr(mk(32'h8000_0000, 5, 1'b1, 32'hFFFF_FFFF, 2, 12'h300, 32'h0, 1'b0, 1'b0), 0);
        idle();
        #1;
        chk1("t1_commit_valid", commit_valid, 1'b1);
        chk("t1_commit_pc", commit_pc, 32'h8000_0000);
        idle();
        #1;
        chk1("t1_commit_drops", commit_valid, 1'b0);
        idle();
        chk("t1_one_pulse", 32'(commit_cnt - c0), 32'd1);
        rd_gpr(5, v);
        chk("t1_x5_mstatus", v, 32'h1800);

        foreach (tbl[k]) begin
            run_instr(tbl[k].i, 0);
            idle();
            rd_gpr(tbl[k].chk_reg, v);
            chk($sformatf("vec%0d", k), v, tbl[k].exp);
        end

        // Back-to-back writes with bypass observation
        c0 = commit_cnt;
        run_instr(mk(32'h8000_0100, 1, 1'b1, 32'hDEAD_BEEF, 0, 12'h0, 32'h0, 1'b0, 1'b0), 0);
        run_instr(mk(32'h8000_0104, 2, 1'b1, 32'h1234_5678, 0, 12'h0, 32'h0, 1'b0, 1'b0), 0);
        rs_addr = {5'd2, 5'd1};
        #1;
        chk("t2_bypass_x1", rs_data[31:0], 32'hDEAD_BEEF);
        chk("t2_x2_not_yet", rs_data[63:32], 32'h0);
        chk("t2_commit_pc1", commit_pc, 32'h8000_0100);
        run_instr(mk(32'h8000_0108, 0, 1'b1, 32'h5, 0, 12'h0, 32'h0, 1'b0, 1'b0), 0);
        #1;
        chk("t2_x1_stored", rs_data[31:0], 32'hDEAD_BEEF);
        chk("t2_bypass_x2", rs_data[63:32], 32'h1234_5678);
        chk("t2_commit_pc2", commit_pc, 32'h8000_0104);
        idle();
        rs_addr = {5'd2, 5'd0};
        #1;
        chk1("t2_x0_commit_valid", commit_valid, 1'b1);
        chk("t2_x0_no_bypass", rs_data[31:0], 32'h0);
        chk("t2_commit_pc3", commit_pc, 32'h8000_0108);
        idle();
        idle();
        chk("t2_three_pulses", 32'(commit_cnt - c0), 32'd3);

        // ecall with a stalled IFU, then mret, then ecall+mret together
        run_instr(mk(32'h8000_0010, 3, 1'b1, 32'h77, 1, 12'h305, 32'h0, 1'b1, 1'b0), 2);
        rd_csr(12'h341, v);
        chk("t4_mepc", v, 32'h8000_0010);
        rd_csr(12'h342, v);
        chk("t4_mcause", v, 32'd11);
        rd_csr(12'h305, v);
        chk("t4_mtvec_untouched", v, 32'h8000_0100);
        rd_gpr(3, v);
        chk("t4_no_gpr_write", v, 32'h0);
        run_instr(mk(32'h8000_0200, 0, 1'b0, 32'h0, 0, 12'h0, 32'h0, 1'b0, 1'b1), 1);
        rd_csr(12'h300, v);
        chk("t5_mstatus_kept", v, 32'h1800);
        run_instr(mk(32'h8000_0020, 0, 1'b0, 32'h0, 0, 12'h0, 32'h0, 1'b1, 1'b1), 0);
        rd_csr(12'h341, v);
        chk("t5_ecall_wins_mepc", v, 32'h8000_0020);

        for (int n = 0; n < 300; n++) begin
            int kind;
            kind = $urandom_range(0, 9);
            ri = mk($urandom() & 32'hFFFF_FFFC, $urandom_range(0, 31), $urandom_range(0, 3) != 0,
                    $urandom(), 0, rand_addr(), $urandom(), 1'b0, 1'b0);
            if (kind >= 4 && kind <= 7) ri.op = 2'($urandom_range(1, 3));
            if (kind == 8) begin
                ri.ecall = 1'b1;
                ri.mret = 1'($urandom_range(0, 1));
                ri.op = 2'($urandom_range(0, 3));
            end
            if (kind == 9) ri.mret = 1'b1;
            run_instr(ri, $urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) idle();
        end
        idle();
        idle();
        chk("rand_commit_count", 32'(commit_cnt), 32'(exp_commits));
        for (int r = 0; r < 32; r++) begin
            rd_gpr(r, v);
            chk($sformatf("rand_x%0d_p0", r), v, m_gpr[r]);
            chk($sformatf("rand_x%0d_p1", r), rs_data[63:32], m_gpr[r]);
        end
        begin
            logic [31:0] e;
            e = m_mstatus; rd_csr(12'h300, v); chk("rand_mstatus", v, e);
            e = m_mtvec;   rd_csr(12'h305, v); chk("rand_mtvec", v, e);
            e = m_mepc;    rd_csr(12'h341, v); chk("rand_mepc", v, e);
            e = m_mcause;  rd_csr(12'h342, v); chk("rand_mcause", v, e);
        end

        // Reset while an ecall waits in REDIRECT
        @(negedge clk);
        drive(mk(32'h8000_0040, 0, 1'b0, 32'h0, 0, 12'h0, 32'h0, 1'b1, 1'b0));
        @(negedge clk);
        in_valid = 1'b0; in_ecall = 1'b0;
        #1;
        chk1("t6_in_redirect", redirect_valid, 1'b1);
        rst = 1'b0;
        #1;
        chk1("t6_async_drop", redirect_valid, 1'b0);
        chk1("t6_ready_in_reset", in_ready, 1'b1);
        chk1("t6_no_commit", commit_valid, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        rd_csr(12'h341, v);
        chk("t6_mepc_cleared", v, 32'h0);
        rd_gpr(1, v);
        chk("t6_gpr_cleared", v, 32'h0);

        // NR_REGS=16: x20 must be dropped and must not alias x4
        @(negedge clk);
        s_in_valid = 1'b1; s_in_rd = 5'd20; s_in_rd_wen = 1'b1; s_in_rd_data = 32'hCAFE;
        @(negedge clk);
        s_in_rd = 5'd3; s_in_rd_data = 32'h77;
        s_rs_addr = {5'd4, 5'd20};
        #1;
        chk1("t6_16_commit", s_commit_valid, 1'b1);
        chk("t6_16_x20_no_bypass", s_rs_data[31:0], 32'h0);
        @(negedge clk);
        s_in_valid = 1'b0;
        @(negedge clk);
        s_rs_addr = {5'd4, 5'd3};
        #1;
        chk("t6_16_x3", s_rs_data[31:0], 32'h77);
        chk("t6_16_x4_no_alias", s_rs_data[63:32], 32'h0);
        s_rs_addr = {5'd4, 5'd20};
        #1;
        chk("t6_16_x20_reads0", s_rs_data[31:0], 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
